emulib_ram_scan_adapter: RTL and testbench
==========================================

// Module: emulib_ram_scan_adapter
// PURPOSE
//  Responder end of the memory scan interface (ram_sr/ram_se/ram_sd/ram_di/ram_do) driven by the scan-chain controller.
//  Wraps one DUT memory (DEPTH x WIDTH) and gives the DUT a normal 1-port sync RAM port.
//  When scanned, walks the memory sequentially: scan-in loads words from ram_di, scan-out streams words to ram_do.
//  Scan-out has a fixed 2-beat pipeline, matched by the controller's two prep beats before data capture.
// PARAMETERS
//  DEPTH       16                      number of memory words (>=1); one scan beat per word
//  WIDTH       64                      word width, 1..64; scan word is zero-extended/truncated to 64 bits
//  ADDR_WIDTH  $clog2(DEPTH)>1?..:1    derived, address width (min 1)
// PORTS
//  host_clk   in   1           single clock
//  host_rst   in   1           synchronous, active-high reset
//  ram_sr     in   1           scan reset: zero address counter, flush read pipeline
//  ram_se     in   1           scan enable: one beat per cycle asserted
//  ram_sd     in   1           scan direction: 1 = scan-in (write memory), 0 = scan-out (read memory)
//  ram_di     in   64          scan-in data, bits [WIDTH-1:0] used
//  ram_do     out  64          scan-out data, upper 64-WIDTH bits zero
//  dut_en     in   1           DUT access enable
//  dut_wen    in   1           DUT write (with dut_en)
//  dut_addr   in   ADDR_WIDTH  DUT address
//  dut_wdata  in   WIDTH       DUT write data
//  dut_rdata  out  WIDTH       DUT read data, 1-cycle latency
// BEHAVIOUR
//  Reset: scan addr counter=0, pipeline regs s1/s2=0, ram_do=0, dut_rdata=0; memory contents NOT reset.
//  scan_active = ram_sr | ram_se. While scan_active, DUT access suppressed: no write, dut_rdata holds last value.
//  ram_sr (priority over ram_se same cycle): addr<=0, s1<=0, s2<=0; no memory access that cycle.
//  Scan-in beat (ram_se & ram_sd): mem[addr]<=ram_di[WIDTH-1:0]; addr<=addr+1.
//  Scan-out beat (ram_se & !ram_sd): s1<=mem[addr]; s2<=s1; addr<=addr+1. ram_do = zext(s2), registered.
//   => during the n-th scan-out beat after ram_sr (n from 0), ram_do = mem[n-2]; beats 0,1 are prep beats.
//  Pipeline advances ONLY on ram_se; idle cycles (se=0) hold addr, s1, s2, ram_do (controller may stall on DMA).
//  Address wrap: addr==DEPTH-1 +1 -> 0 (no saturation); extra scan-out prep reads past end are harmless.
//  ram_sd change mid-sequence: no state reset; controller must issue ram_sr. Direction sampled per beat.
//  DUT port (!scan_active & dut_en): dut_wen -> mem[dut_addr]<=dut_wdata; else dut_rdata<=mem[dut_addr] next cycle.
//  DUT write and DUT read same address: write-first not required; read-before-write (old data) returned.
//  dut_addr >= DEPTH (non-power-of-2): writes dropped, reads return 0.
//  host_rst mid-scan: counter/pipeline cleared as above; partially scanned memory keeps written words.
//  Single physical memory port: scan and DUT muxed onto it; scan has absolute priority.
// STRUCTURE
//  Shared package (emulib_scan_pkg): SCAN_DIR_OUT=1'b0, SCAN_DIR_IN=1'b1, SCAN_WORD_WIDTH=64, SCAN_OUT_LATENCY=2.
//  Sub-module emulib_scan_ram_core: DEPTH x WIDTH single-port sync RAM (en, wen, addr, wdata, rdata), BRAM-inferable.
//  Top holds scan addr counter, port mux, s2 stage (s1 is the core's rdata register, enabled by se).
// TESTING
//  1 DEPTH=4,WIDTH=32: sr; 4 scan-in beats di=0x11..0x44 -> DUT reads addr0..3 return 0x11,0x22,0x33,0x44.
//  2 DUT writes 0xA0..0xA3 to addr0..3; sr; 6 scan-out beats -> ram_do at beats 2..5 = 0xA0..0xA3, upper 32 bits 0.
//  3 Scan-out with se gaps (se=1,0,0,1,1,0,1,...) -> same data order as scenario 2, ram_do stable during gaps.
//  4 DUT write addr1=0xFF while ram_se=1 -> dropped; later DUT read addr1 returns scanned value, not 0xFF.
//  5 DEPTH=3: 5 scan-in beats 1..5 -> mem = {4,5,3} (wrap to addr0 after addr2).
//  6 host_rst after 2 scan-in beats, then sr + scan-out -> counter restarts at 0, ram_do=0 right after reset.

Source files
------------

// File: rtl/emulib_scan_pkg.sv
// Constants shared by the memory scan controller and its per-memory adapters.
package emulib_scan_pkg;
  localparam logic        SCAN_DIR_OUT     = 1'b0;
  localparam logic        SCAN_DIR_IN      = 1'b1;
  localparam int unsigned SCAN_WORD_WIDTH  = 64;
  localparam int unsigned SCAN_OUT_LATENCY = 2;
endpackage

// File: rtl/emulib_scan_ram_core.sv
// DEPTH x WIDTH single-port synchronous RAM with registered read data.
module emulib_scan_ram_core #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (wen) mem_q[addr] <= wdata;
      else     rdata_q     <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/emulib_ram_scan_adapter.sv
// Scan responder for one DUT memory: sequential scan-in/scan-out walker muxed
// with the DUT's own single-port access onto one physical RAM port.
module emulib_ram_scan_adapter
  import emulib_scan_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       host_clk,
  input  logic                       host_rst,
  input  logic                       ram_sr,
  input  logic                       ram_se,
  input  logic                       ram_sd,
  input  logic [SCAN_WORD_WIDTH-1:0] ram_di,
  output logic [SCAN_WORD_WIDTH-1:0] ram_do,
  input  logic                       dut_en,
  input  logic                       dut_wen,
  input  logic [ADDR_WIDTH-1:0]      dut_addr,
  input  logic [WIDTH-1:0]           dut_wdata,
  output logic [WIDTH-1:0]           dut_rdata
);

  logic [ADDR_WIDTH-1:0] scan_addr_q, scan_addr_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0]      s1_hold_q, s1_hold_d;
  logic [WIDTH-1:0]      s2_q, s2_d;
  logic                  dut_rd_vld_q, dut_rd_vld_d;
  logic                  dut_oor_q, dut_oor_d;
  logic [WIDTH-1:0]      dut_hold_q, dut_hold_d;

  logic                  scan_active_c, scan_in_beat_c, scan_out_beat_c, dut_ok_c;
  logic                  core_en_c, core_wen_c;
  logic [ADDR_WIDTH-1:0] core_addr_c;
  logic [WIDTH-1:0]      core_wdata_c, core_rdata;
  logic [WIDTH-1:0]      s1_c, dut_rdata_c;
  logic                  unused_di_c;

  assign unused_di_c = ^ram_di;

  // Port mux: any scan activity owns the RAM; DUT gets it only when scan is idle.
  always_comb begin
    scan_active_c   = ram_sr | ram_se;
    scan_in_beat_c  = ram_se & ~ram_sr & (ram_sd == SCAN_DIR_IN);
    scan_out_beat_c = ram_se & ~ram_sr & (ram_sd == SCAN_DIR_OUT);
    dut_ok_c        = ~scan_active_c & dut_en & (32'(dut_addr) < DEPTH);
    core_en_c       = scan_in_beat_c | scan_out_beat_c | dut_ok_c;
    core_wen_c      = scan_in_beat_c | (dut_ok_c & dut_wen);
    core_addr_c     = (scan_in_beat_c | scan_out_beat_c) ? scan_addr_q : dut_addr;
    core_wdata_c    = scan_in_beat_c ? ram_di[WIDTH-1:0] : dut_wdata;
  end

  emulib_scan_ram_core #(
    .DEPTH      (DEPTH),
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk   (host_clk),
    .en    (core_en_c),
    .wen   (core_wen_c),
    .addr  (core_addr_c),
    .wdata (core_wdata_c),
    .rdata (core_rdata)
  );

  // The core's read register is s1 right after a scan read; a shadow keeps it
  // stable across stalls in case an interleaved DUT read reuses the port.
  always_comb begin
    s1_c        = s1_vld_q ? core_rdata : s1_hold_q;
    dut_rdata_c = dut_rd_vld_q ? (dut_oor_q ? '0 : core_rdata) : dut_hold_q;
  end

  always_comb begin
    scan_addr_d  = scan_addr_q;
    s1_vld_d     = scan_out_beat_c;
    s1_hold_d    = s1_c;
    s2_d         = s2_q;
    dut_rd_vld_d = ~scan_active_c & dut_en & ~dut_wen;
    dut_oor_d    = ~(32'(dut_addr) < DEPTH);
    dut_hold_d   = dut_rdata_c;
    if (ram_sr) begin
      scan_addr_d = '0;
      s1_vld_d    = 1'b0;
      s1_hold_d   = '0;
      s2_d        = '0;
    end else if (ram_se) begin
      scan_addr_d = (scan_addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0
                                                            : scan_addr_q + ADDR_WIDTH'(1);
      if (scan_out_beat_c) s2_d = s1_c;
    end
  end

  always_ff @(posedge host_clk) begin
    if (host_rst) begin
      scan_addr_q  <= '0;
      s1_vld_q     <= 1'b0;
      s1_hold_q    <= '0;
      s2_q         <= '0;
      dut_rd_vld_q <= 1'b0;
      dut_oor_q    <= 1'b0;
      dut_hold_q   <= '0;
    end else begin
      scan_addr_q  <= scan_addr_d;
      s1_vld_q     <= s1_vld_d;
      s1_hold_q    <= s1_hold_d;
      s2_q         <= s2_d;
      dut_rd_vld_q <= dut_rd_vld_d;
      dut_oor_q    <= dut_oor_d;
      dut_hold_q   <= dut_hold_d;
    end
  end

  assign ram_do    = SCAN_WORD_WIDTH'(s2_q);
  assign dut_rdata = dut_rdata_c;

endmodule

// File: tb/tb_emulib_ram_scan_adapter.sv
// Directed bench for emulib_ram_scan_adapter: a DEPTH=4 and a DEPTH=3 instance.
module tb_emulib_ram_scan_adapter;
  import emulib_scan_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sr0, se0, sd0, en0, wen0;
  logic [63:0] di0, do0;
  logic [1:0]  addr0;
  logic [31:0] wdata0, rdata0;

  logic        sr1, se1, sd1, en1, wen1;
  logic [63:0] di1, do1;
  logic [1:0]  addr1;
  logic [31:0] wdata1, rdata1;

  emulib_ram_scan_adapter #(.DEPTH(4), .WIDTH(32)) u0 (
    .host_clk (clk),   .host_rst (rst),
    .ram_sr   (sr0),   .ram_se   (se0),  .ram_sd (sd0),
    .ram_di   (di0),   .ram_do   (do0),
    .dut_en   (en0),   .dut_wen  (wen0), .dut_addr (addr0),
    .dut_wdata(wdata0), .dut_rdata(rdata0)
  );

  emulib_ram_scan_adapter #(.DEPTH(3), .WIDTH(32)) u1 (
    .host_clk (clk),   .host_rst (rst),
    .ram_sr   (sr1),   .ram_se   (se1),  .ram_sd (sd1),
    .ram_di   (di1),   .ram_do   (do1),
    .dut_en   (en1),   .dut_wen  (wen1), .dut_addr (addr1),
    .dut_wdata(wdata1), .dut_rdata(rdata1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] mem_m [4];
  logic        se_pat [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scan-out from sr over 6 beats, checking ram_do against the memory model.
  task automatic scan_out_u0(input string tag);
    sr0 = 1'b1; step(); sr0 = 1'b0;
    se0 = 1'b1; sd0 = SCAN_DIR_OUT;
    for (int n = 0; n < 6; n++) begin
      check(tag, do0, (n >= int'(SCAN_OUT_LATENCY)) ? 64'(mem_m[n - 2]) : 64'h0);
      step();
    end
    se0 = 1'b0;
    step();
    check({tag, "_hold"}, do0, 64'(mem_m[0]));
  endtask

  initial begin
    rst = 1'b1;
    {sr0, se0, sd0, en0, wen0} = '0; di0 = '0; addr0 = '0; wdata0 = '0;
    {sr1, se1, sd1, en1, wen1} = '0; di1 = '0; addr1 = '0; wdata1 = '0;
    step(); step();
    check("rst_do0", do0, 64'h0);
    check("rst_rd0", 64'(rdata0), 64'h0);
    check("rst_do1", do1, 64'h0);
    check("rst_rd1", 64'(rdata1), 64'h0);
    rst = 1'b0;

    // 1: scan-in 0x11..0x44 (upper di bits must be ignored), read back via DUT port
    sr0 = 1'b1; step(); sr0 = 1'b0;
    se0 = 1'b1; sd0 = SCAN_DIR_IN;
    for (int i = 0; i < 4; i++) begin
      di0 = {32'hDEAD_BEEF, 32'h11 * 32'(i + 1)};
      step();
    end
    se0 = 1'b0;
    en0 = 1'b1; wen0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr0 = 2'(i);
      step();
      check("s1_rd", 64'(rdata0), 64'h11 * 64'(i + 1));
    end
    en0 = 1'b0;

    // 2: DUT writes 0xA0..0xA3, scan-out
    en0 = 1'b1; wen0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr0 = 2'(i); wdata0 = 32'hA0 + 32'(i); mem_m[i] = 32'hA0 + 32'(i);
      step();
    end
    en0 = 1'b0; wen0 = 1'b0;
    scan_out_u0("s2_do");
    check("s2_hi", 64'(do0[63:32]), 64'h0);

    // 3: scan-out with se gaps; DUT reads addr3 during gaps
    sr0 = 1'b1; step(); sr0 = 1'b0;
    sd0 = SCAN_DIR_OUT; wen0 = 1'b0; addr0 = 2'd3;
    begin
      int k;
      k = 0;
      for (int c = 0; c < 10; c++) begin
        se0 = se_pat[c]; en0 = ~se_pat[c];
        check("s3_do", do0, (k >= 2) ? 64'(mem_m[(k - 2) % 4]) : 64'h0);
        step();
        if (se_pat[c]) k++;
      end
      se0 = 1'b0; en0 = 1'b0;
      check("s3_do_end", do0, 64'(mem_m[(k - 2) % 4]));
    end
    check("s3_rd", 64'(rdata0), 64'hA3);

    // 4: DUT write during scan is dropped, dut_rdata holds
    se0 = 1'b1; sd0 = SCAN_DIR_OUT; en0 = 1'b1; wen0 = 1'b1; addr0 = 2'd1; wdata0 = 32'hFF;
    step();
    check("s4_hold", 64'(rdata0), 64'hA3);
    se0 = 1'b0; wen0 = 1'b0;
    step();
    check("s4_rd", 64'(rdata0), 64'hA1);
    en0 = 1'b0;

    // 5: DEPTH=3 wrap, then out-of-range DUT access
    sr1 = 1'b1; step(); sr1 = 1'b0;
    se1 = 1'b1; sd1 = SCAN_DIR_IN;
    for (int i = 0; i < 5; i++) begin
      di1 = 64'(i + 1);
      step();
    end
    se1 = 1'b0;
    en1 = 1'b1; wen1 = 1'b0;
    addr1 = 2'd0; step(); check("s5_rd0", 64'(rdata1), 64'h4);
    addr1 = 2'd1; step(); check("s5_rd1", 64'(rdata1), 64'h5);
    addr1 = 2'd2; step(); check("s5_rd2", 64'(rdata1), 64'h3);
    wen1 = 1'b1; addr1 = 2'd3; wdata1 = 32'h99; step();
    wen1 = 1'b0; step(); check("s5_oor", 64'(rdata1), 64'h0);
    addr1 = 2'd0; step(); check("s5_rd0b", 64'(rdata1), 64'h4);
    en1 = 1'b0;

    // 6: host_rst mid scan-in restarts the counter; written words kept
    sr0 = 1'b1; step(); sr0 = 1'b0;
    se0 = 1'b1; sd0 = SCAN_DIR_IN;
    di0 = 64'h55; step();
    di0 = 64'h66; step();
    se0 = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    check("s6_rst_do", do0, 64'h0);
    check("s6_rst_rd", 64'(rdata0), 64'h0);
    se0 = 1'b1; sd0 = SCAN_DIR_IN; di0 = 64'h77; step();
    se0 = 1'b0;
    mem_m[0] = 32'h77; mem_m[1] = 32'h66;
    scan_out_u0("s6_do");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
